// File: rtl/mkio_pkg.sv
// Shared types for the MKIO remote-terminal scheduler: command word layout,
// scheduler states and the saturating counter helper.
package mkio_pkg;

    typedef struct packed {
        logic [4:0] addr;
        logic       tr;
        logic [4:0] sa;
        logic [4:0] wc;
    } cmd_word_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        SERVE,
        DRAIN
    } sched_state_t;

    localparam logic [4:0] BCAST_ADDR = 5'd31;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/mkio_tx_mux.sv
// NDEV-way selector of device transmit data/cd/ready towards the single encoder;
// everything is held at zero while en is low.
module mkio_tx_mux #(
    parameter int NDEV  = 4,
    parameter int SEL_W = 2
) (
    input  logic [NDEV*16-1:0] dev_tx_data,
    input  logic [NDEV-1:0]    dev_tx_cd,
    input  logic [NDEV-1:0]    dev_tx_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [15:0]        tx_data,
    output logic               tx_cd,
    output logic               tx_ready
);

    always_comb begin
        // NOTE: every output gets a default before the conditional, so no latch is inferred.
        tx_data  = '0;
        tx_cd    = 1'b0;
        tx_ready = 1'b0;
        if (en) begin
            tx_data  = dev_tx_data[16*int'(sel) +: 16];
            tx_cd    = dev_tx_cd[sel];
            tx_ready = dev_tx_ready[sel];
        end
    end

endmodule

// File: rtl/mkio_rt_sched.sv
// MKIO remote-terminal command scheduler: decodes transmit commands, starts one
// subaddress device and lends it the encoder. Define MKIO_STATS_EN for msg/err counters.
module mkio_rt_sched
    import mkio_pkg::*;
#(
    parameter logic [4:0]  RT_ADDR    = 5'd1,
    parameter int          NDEV       = 4,
    parameter logic [4:0]  SA_BASE    = 5'd1,
    parameter int          START_WAIT = 4,
    parameter logic [15:0] TIMEOUT    = 16'd4000,
    localparam int         SEL_W      = $clog2(NDEV)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_cd,
    input  logic                 p_error,
    output logic [15:0]          cmd_word,
    output logic [NDEV-1:0]      dev_start,
    input  logic [NDEV-1:0]      dev_busy,
    input  logic [NDEV*16-1:0]   dev_tx_data,
    input  logic [NDEV-1:0]      dev_tx_cd,
    input  logic [NDEV-1:0]      dev_tx_ready,
    output logic [15:0]          tx_data,
    output logic                 tx_cd,
    output logic                 tx_ready,
    input  logic                 tx_busy,
    output logic                 active,
    output logic [SEL_W-1:0]     sel,
    output logic                 timeout_err,
    output logic [15:0]          msg_count,
    output logic [15:0]          err_count
);

    sched_state_t      state;
    logic [15:0]       cnt;
    cmd_word_t         rx_f;
    logic [SEL_W-1:0]  sa_idx;
    logic [NDEV-1:0]   start_vec;
    logic              sa_in_range;
    logic              accept;
    logic              take;
    logic              wait_timeout;
    logic              serve_timeout;

    assign rx_f        = cmd_word_t'(rx_data);
    assign sa_idx      = SEL_W'(rx_f.sa - SA_BASE);
    assign start_vec   = NDEV'(1) << sa_idx;
    assign sa_in_range = (rx_f.sa >= SA_BASE) && (int'(rx_f.sa) < int'(SA_BASE) + NDEV);
    assign accept      = rx_valid && rx_cd && !p_error && (rx_f.addr == RT_ADDR)
                         && rx_f.tr && sa_in_range;
    // A command arriving during the one-cycle start pulse is dropped so the pulse stays single.
    assign take        = accept && (state != START);

    assign wait_timeout  = (state == WAIT_BUSY) && !dev_busy[sel] && (cnt == 16'(START_WAIT - 1));
    assign serve_timeout = (state == SERVE) && dev_busy[sel] && (cnt == TIMEOUT - 16'd1);

    assign active = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_word    <= '0;
            sel         <= '0;
            dev_start   <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            dev_start <= '0;
            if (take) begin
                cmd_word  <= rx_f;
                sel       <= sa_idx;
                dev_start <= start_vec;
                state     <= START;
            end else begin
                case (state)
                    IDLE: ;
                    START: begin
                        state <= WAIT_BUSY;
                        cnt   <= '0;
                    end
                    WAIT_BUSY: begin
                        if (dev_busy[sel]) begin
                            state <= SERVE;
                            cnt   <= '0;
                        end else if (wait_timeout) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    SERVE: begin
                        if (!dev_busy[sel]) begin
                            state <= DRAIN;
                        end else if (serve_timeout) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    DRAIN: if (!tx_busy) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MKIO_STATS_EN
    logic       reject;
    logic       supersede;
    logic       to_evt;
    logic [1:0] err_inc;

    // Broadcast words are counted as rejects; other foreign addresses are not ours to count.
    assign reject    = rx_valid && rx_cd && !accept
                       && ((rx_f.addr == RT_ADDR) || (rx_f.addr == BCAST_ADDR));
    assign supersede = accept && ((state == WAIT_BUSY) || (state == SERVE) || (state == DRAIN));
    assign to_evt    = (wait_timeout || serve_timeout) && !take;
    assign err_inc   = 2'(reject) + 2'(supersede) + 2'(to_evt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_count <= '0;
            err_count <= '0;
        end else begin
            msg_count <= sat_add(msg_count, {1'b0, state == START});
            err_count <= sat_add(err_count, err_inc);
        end
    end
`else
    assign msg_count = '0;
    assign err_count = '0;
`endif

    mkio_tx_mux #(
        .NDEV  (NDEV),
        .SEL_W (SEL_W)
    ) u_tx_mux (
        .dev_tx_data  (dev_tx_data),
        .dev_tx_cd    (dev_tx_cd),
        .dev_tx_ready (dev_tx_ready),
        .sel          (sel),
        .en           (state == SERVE),
        .tx_data      (tx_data),
        .tx_cd        (tx_cd),
        .tx_ready     (tx_ready)
    );

endmodule
